// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial LSB-first ripple adder, one sum bit per clock.
//               Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               w_s;
    logic               w_c_next;
    logic [WIDTH-1:0]   w_a_shift;

    assign w_s      = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // Sum bits enter at the MSB while consumed operand-A bits leave the LSB,
    // so after WIDTH shifts this register holds the complete result.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_a_shift = w_s;
        end else begin : g_shift_wn
            assign w_a_shift = {w_s, a_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = w_a_shift;
                b_d     = b_q >> 1;
                carry_d = w_c_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    state_d = DONE;
                    sum_d   = w_a_shift;
                    cout_d  = w_c_next;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this last step
                    ovf_d   = carry_q ^ w_c_next;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder, WIDTH=8 and WIDTH=1 units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

`ifdef SERIAL_ADDER_OVF_EN
    localparam logic c_OVF_ON = 1'b1;
`else
    localparam logic c_OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] q8[$];
    logic [2:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL dut8_unexpected_done: got sum=%0h cout=%0b ovf=%0b expected no done",
                         sum8, cout8, ovf8);
            end else begin
                logic [9:0] e;
                e = q8.pop_front();
                if ({sum8, cout8, ovf8} !== e) begin
                    errors++;
                    $display("FAIL dut8_result: got sum=%0h cout=%0b ovf=%0b expected sum=%0h cout=%0b ovf=%0b",
                             sum8, cout8, ovf8, e[9:2], e[1], e[0]);
                end
            end
        end
        if (done1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_done: got sum=%0b cout=%0b expected no done", sum1, cout1);
            end else begin
                logic [2:0] e;
                e = q1.pop_front();
                if ({sum1, cout1, ovf1} !== e) begin
                    errors++;
                    $display("FAIL dut1_result: got sum=%0b cout=%0b ovf=%0b expected sum=%0b cout=%0b ovf=%0b",
                             sum1, cout1, ovf1, e[2], e[1], e[0]);
                end
            end
        end
    end

    // Called at the first negedge of RUN; counts busy cycles then expects done.
    task automatic wait_done8(input int exp_busy);
        int n;
        n = 0;
        while (busy8 === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("dut8_busy_cycles", n, exp_busy);
        chk("dut8_done_after_busy", done8, 1);
    endtask

    // Returns at the negedge inside DONE so the next start hits the earliest edge.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        q8.push_back({es, ec, eo & c_OVF_ON});
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(8);
    endtask

    task automatic run1(input logic ta, input logic tb_, input logic es, input logic ec, input logic eo);
        @(negedge clk);
        a1 = ta; b1 = tb_; cin1 = 1'b0; start1 = 1'b1;
        q1.push_back({es, ec, eo & c_OVF_ON});
        @(negedge clk);
        start1 = 1'b0;
        chk("dut1_busy", busy1, 1);
        @(negedge clk);
        chk("dut1_done_timing", done1, 1);
        chk("dut1_busy_in_done", busy1, 0);
    endtask

    initial begin
        #12;
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_sum", sum8, 0);
        chk("reset_cout", cout8, 0);
        chk("reset_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // start held high with operand A changed mid-run
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
        q8.push_back({8'h31, 1'b0, 1'b0});
        @(negedge clk);
        a8 = 8'hFF;
        wait_done8(8);
        q8.push_back({8'h20, 1'b1, 1'b0});
        @(negedge clk);
        chk("hold_start_ignored_in_done", busy8, 0);
        chk("hold_sum_stable", sum8, 8'h31);
        @(negedge clk);
        chk("hold_second_start_accepted", busy8, 1);
        start8 = 1'b0;
        wait_done8(8);

        // reset during the 4th RUN cycle
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", busy8, 0);
        chk("async_reset_sum", sum8, 0);
        chk("async_reset_cout", cout8, 0);
        chk("async_reset_done", done8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_busy_after_reset", busy8, 0);
        run8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        run1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
